// File: rtl/spi_shiftreg_wide.sv
`timescale 1ns / 1ps
// Wide SPI transfer buffer: loaded word-wise from the bus, shifted out/in one bit per edge pulse.
// Received bits overwrite transmitted bits in place; bits at index >= transfer length are untouched.
module spi_shiftreg_wide #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BUS_W  = 32,
  parameter int unsigned LEN_W  = 7,
  parameter int unsigned NWORDS = DATA_W / BUS_W
) (
  input  logic                 wb_clk_in,
  input  logic                 wb_rst,
  input  logic                 cpol_0,
  input  logic                 cpol_1,
  input  logic                 rx_negedge,
  input  logic                 tx_negedge,
  input  logic                 lsb,
  input  logic                 go,
  input  logic [LEN_W-1:0]     len,
  input  logic [NWORDS-1:0]    latch,
  input  logic [BUS_W/8-1:0]   byte_sel,
  input  logic [BUS_W-1:0]     p_in,
  input  logic                 miso,
  output logic                 mosi,
  output logic                 tip,
  output logic                 last,
  output logic                 done,
  output logic [DATA_W-1:0]    p_out
);

  localparam int unsigned CNT_W  = LEN_W + 1;
  localparam int unsigned NBYTES = BUS_W / 8;

  logic [DATA_W-1:0] r_buf, w_buf_d;
  logic [CNT_W-1:0]  r_rx_cnt, r_tx_cnt, w_len, w_rx_cnt_inc;
  logic              r_tip, r_mosi, r_done;
  logic              w_rx_pulse, w_tx_pulse, w_rx_en, w_tx_en;
  logic              w_write, w_start, w_end;
  logic [LEN_W-1:0]  w_rx_idx, w_tx_idx, w_first_idx;

  function automatic logic [LEN_W-1:0] bit_idx(input logic [CNT_W-1:0] i,
                                               input logic [CNT_W-1:0] l,
                                               input logic             lsb_first);
    logic [CNT_W-1:0] v;
    v = lsb_first ? i : (l - CNT_W'(1) - i);
    return v[LEN_W-1:0];
  endfunction

  assign w_len        = (len == '0) ? CNT_W'(DATA_W) : {1'b0, len};
  assign w_rx_pulse   = rx_negedge ? cpol_1 : cpol_0;
  assign w_tx_pulse   = tx_negedge ? cpol_1 : cpol_0;
  assign w_rx_en      = r_tip & w_rx_pulse & (r_rx_cnt < w_len);
  assign w_rx_cnt_inc = r_rx_cnt + CNT_W'(w_rx_en);
  // tx may not run ahead of rx, so the preloaded bit survives until it has been sampled
  assign w_tx_en      = r_tip & w_tx_pulse & (r_tx_cnt < w_len) & (w_rx_cnt_inc >= r_tx_cnt);
  assign w_end        = w_rx_en & (w_rx_cnt_inc == w_len);
  assign w_write      = ~r_tip & (|latch);
  assign w_start      = ~r_tip & go & ~(|latch);

  assign w_rx_idx    = bit_idx(r_rx_cnt, w_len, lsb);
  assign w_tx_idx    = bit_idx(r_tx_cnt, w_len, lsb);
  assign w_first_idx = bit_idx('0, w_len, lsb);

  always_comb begin
    w_buf_d = r_buf;
    if (w_write) begin
      for (int k = 0; k < int'(NWORDS); k++) begin
        for (int j = 0; j < int'(NBYTES); j++) begin
          if (latch[k] && byte_sel[j]) begin
            w_buf_d[k*BUS_W + j*8 +: 8] = p_in[j*8 +: 8];
          end
        end
      end
    end
    if (w_rx_en) begin
      w_buf_d[w_rx_idx] = miso;
    end
  end

  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      r_buf    <= '0;
      r_tip    <= 1'b0;
      r_mosi   <= 1'b0;
      r_done   <= 1'b0;
      r_rx_cnt <= '0;
      r_tx_cnt <= '0;
    end else begin
      r_buf  <= w_buf_d;
      r_done <= w_end;
      if (w_start) begin
        r_tip    <= 1'b1;
        r_mosi   <= r_buf[w_first_idx];
        r_rx_cnt <= '0;
        r_tx_cnt <= CNT_W'(1);
      end else if (r_tip) begin
        r_rx_cnt <= w_rx_cnt_inc;
        // reads the pre-edge buffer, so a coincident rx write cannot corrupt it
        if (w_tx_en) begin
          r_mosi   <= r_buf[w_tx_idx];
          r_tx_cnt <= r_tx_cnt + CNT_W'(1);
        end
        if (w_end) begin
          r_tip <= 1'b0;
        end
      end
    end
  end

  assign mosi  = r_mosi;
  assign tip   = r_tip;
  assign done  = r_done;
  assign p_out = r_buf;
  assign last  = r_tip & (r_rx_cnt == (w_len - CNT_W'(1)));

endmodule

// File: tb/tb_spi_shiftreg_wide.sv
`timescale 1ns / 1ps
// Directed bench for spi_shiftreg_wide: an SPI edge-pulse emulator drives transfers and
// results are compared against hand-computed buffer/serial values.
module tb_spi_shiftreg_wide;

  logic         clk = 1'b0;
  logic         wb_rst, cpol_0, cpol_1, rx_negedge, tx_negedge, lsb, go, miso;
  logic [6:0]   len;
  logic [3:0]   latch, byte_sel;
  logic [31:0]  p_in;
  logic         mosi, tip, last, done;
  logic [127:0] p_out;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] LbData = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d};

  always #5 clk = ~clk;

  spi_shiftreg_wide dut (
    .wb_clk_in (clk),
    .wb_rst    (wb_rst),
    .cpol_0    (cpol_0),
    .cpol_1    (cpol_1),
    .rx_negedge(rx_negedge),
    .tx_negedge(tx_negedge),
    .lsb       (lsb),
    .go        (go),
    .len       (len),
    .latch     (latch),
    .byte_sel  (byte_sel),
    .p_in      (p_in),
    .miso      (miso),
    .mosi      (mosi),
    .tip       (tip),
    .last      (last),
    .done      (done),
    .p_out     (p_out)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int k, input logic [3:0] be, input logic [31:0] d);
    latch    = 4'(1 << k);
    byte_sel = be;
    p_in     = d;
    step();
    latch    = '0;
    byte_sel = '0;
    p_in     = '0;
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    step();
    wb_rst = 1'b0;
  endtask

  // Runs one transfer, alternating cpol_0 / idle / cpol_1 / idle until tip falls.
  task automatic xfer(input logic rxn, input logic txn, input logic lsbv, input logic [6:0] lenv,
                      input logic loopback, input logic [127:0] miso_v, input int disturb_at,
                      input int abort_rx, output logic [127:0] mosi_v, output int nrx,
                      output int ndone, output logic [127:0] last_v);
    int  l;
    int  c;
    bit  fin;
    bit  is_rx;
    l      = (lenv == 0) ? 128 : int'(lenv);
    c      = 0;
    fin    = 0;
    mosi_v = '0;
    last_v = '0;
    nrx    = 0;
    ndone  = 0;
    rx_negedge = rxn;
    tx_negedge = txn;
    lsb        = lsbv;
    len        = lenv;
    go = 1'b1;
    step();
    go = 1'b0;
    check("start_tip", tip, 1);
    while (!fin && c < 4 * l + 40) begin
      cpol_0 = (c % 4 == 0);
      cpol_1 = (c % 4 == 2);
      is_rx  = rxn ? cpol_1 : cpol_0;
      if (is_rx && tip) begin
        mosi_v[nrx] = mosi;
        last_v[nrx] = last;
        miso        = loopback ? mosi : miso_v[nrx];
        nrx++;
      end
      if (c == disturb_at) begin
        latch    = 4'b0100;
        byte_sel = 4'hf;
        p_in     = 32'hffffffff;
        go       = 1'b1;
      end
      step();
      cpol_0 = 1'b0; cpol_1 = 1'b0;
      latch = '0; byte_sel = '0; p_in = '0; go = 1'b0;
      if (done) ndone++;
      if (abort_rx > 0 && nrx == abort_rx) begin
        do_reset();
        fin = 1;
      end else if (!tip) begin
        fin = 1;
      end
      c++;
    end
    check("xfer_bounded", 1'(fin), 1);
    step();
    if (done) ndone++;
  endtask

  logic [127:0] mv, lv, rev;
  int           nrx, nd;

  initial begin
    wb_rst = 1'b0; cpol_0 = 1'b0; cpol_1 = 1'b0; rx_negedge = 1'b0; tx_negedge = 1'b0;
    lsb = 1'b0; go = 1'b0; miso = 1'b0; len = '0; latch = '0; byte_sel = '0; p_in = '0;
    step();

    do_reset();
    check("rst_mosi", mosi, 0);
    check("rst_tip", tip, 0);
    check("rst_last", last, 0);
    check("rst_done", done, 0);
    check("rst_pout", p_out, 0);

    write_word(3, 4'b1010, 32'h11223344);
    check("partial_write", p_out, {32'h11003300, 96'h0});

    do_reset();
    write_word(0, 4'b0011, 32'h0000aa55);
    xfer(1'b0, 1'b1, 1'b1, 7'd4, 1'b0, 128'b1101, -1, 0, mv, nrx, nd, lv);
    check("m1_mosi", mv[3:0], 4'b0101);
    check("m1_pout_lo", p_out[3:0], 4'b1101);
    check("m1_pout_mid", p_out[15:4], 12'haa5);
    check("m1_pout_hi", p_out[127:16], 0);
    check("m1_nrx", nrx, 4);
    check("m1_last", lv, 128'h8);
    check("m1_done", nd, 1);

    // Edge pulses while idle must not touch the buffer.
    miso = 1'b1; rx_negedge = 1'b0; tx_negedge = 1'b0;
    cpol_0 = 1'b1; step(); cpol_0 = 1'b0; cpol_1 = 1'b1; step(); cpol_1 = 1'b0;
    step();
    check("idle_pout", p_out, {112'h0, 12'haa5, 4'hd});
    check("idle_tip", tip, 0);

    write_word(3, 4'hf, 32'hdeadbeef);
    write_word(2, 4'hf, 32'h01234567);
    write_word(1, 4'hf, 32'h89abcdef);
    write_word(0, 4'hf, 32'hcafef00d);
    check("load_words", p_out, LbData);
    for (int i = 0; i < 128; i++) rev[i] = LbData[127 - i];
    for (int m = 0; m < 4; m++) begin
      xfer(1'(m >> 1), 1'(m), 1'b0, 7'd0, 1'b1, '0, -1, 0, mv, nrx, nd, lv);
      check($sformatf("lb%0d_pout", m), p_out, LbData);
      check($sformatf("lb%0d_first", m), mv[0], 1);
      check($sformatf("lb%0d_mosi", m), mv, rev);
      check($sformatf("lb%0d_nrx", m), nrx, 128);
      check($sformatf("lb%0d_last", m), lv, {1'b1, 127'h0});
      check($sformatf("lb%0d_done", m), nd, 1);
    end

    xfer(1'b0, 1'b0, 1'b0, 7'd8, 1'b1, '0, 5, 0, mv, nrx, nd, lv);
    check("busy_word2", p_out[95:64], 32'h01234567);
    check("busy_pout", p_out, LbData);
    check("busy_nrx", nrx, 8);
    check("busy_done", nd, 1);
    step(); step();
    check("busy_norestart", tip, 0);

    xfer(1'b0, 1'b0, 1'b0, 7'd64, 1'b1, '0, -1, 10, mv, nrx, nd, lv);
    check("abort_tip", tip, 0);
    check("abort_pout", p_out, 0);
    check("abort_done", nd, 0);
    check("abort_nrx", nrx, 10);

    xfer(1'b0, 1'b0, 1'b1, 7'd64, 1'b0, {64'h0, 64'h0123456789abcdef}, -1, 0, mv, nrx, nd, lv);
    check("post_pout", p_out, {64'h0, 64'h0123456789abcdef});
    check("post_mosi", mv, 0);
    check("post_nrx", nrx, 64);
    check("post_last", lv, {64'h0, 1'b1, 63'h0});
    check("post_done", nd, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_shiftreg_wide.md
Name: spi_shiftreg_wide

Overview:
- Parametrised successor to the SPI data shift register. Holds a DATA_W-bit transfer buffer and serialises up to DATA_W bits per transfer.
- The buffer is loaded from a BUS_W-bit Wishbone-side bus one word at a time, with byte enables.
- Supports MSB/LSB-first ordering, independent rx/tx edge selection (all four SPI modes), a last-bit flag and a done pulse.
- Sits between the Wishbone register file and the sclk/edge-pulse generator.

Parameters:
- DATA_W, 128, buffer and maximum transfer length in bits; must equal 2**LEN_W and be a multiple of BUS_W.
- BUS_W, 32, write-bus width; multiple of 8.
- LEN_W, 7, width of len.
- NWORDS, DATA_W/BUS_W, derived; number of bus words in the buffer.

Ports:
- wb_clk_in  in  1  system clock; the only clock.
- wb_rst  in  1  synchronous, active-high reset.
- cpol_0  in  1  one-cycle pulse in the wb_clk_in cycle of each sclk rising transition.
- cpol_1  in  1  one-cycle pulse in the wb_clk_in cycle of each sclk falling transition.
- rx_negedge  in  1  1: sample miso on cpol_1; 0: sample on cpol_0.
- tx_negedge  in  1  1: advance mosi on cpol_1; 0: advance on cpol_0.
- lsb  in  1  1: LSB first; 0: MSB first.
- go  in  1  start request; level, sampled each cycle.
- len  in  LEN_W  transfer length; 0 encodes DATA_W.
- latch  in  NWORDS  one-hot word-write select.
- byte_sel  in  BUS_W/8  byte enables for the write.
- p_in  in  BUS_W  write data.
- miso  in  1  serial input.
- mosi  out  1  serial output.
- tip  out  1  transfer in progress.
- last  out  1  next rx sample is the final bit.
- done  out  1  one-cycle pulse at end of transfer.
- p_out  out  DATA_W  buffer contents.

Behaviour:
- Reset: mosi=0, tip=0, last=0, done=0, buffer=0 (so p_out=0), all counters=0. Reset takes priority over every other input, including mid-transfer; no done pulse is generated for an aborted transfer.
- L = (len==0) ? DATA_W : len.
- Bit order by transfer index i = 0..L-1:
  - MSB first: buffer bit L-1-i.
  - LSB first: buffer bit i.
- Write path:
  - Active when tip=0 and latch[k]=1.
  - Each byte j with byte_sel[j]=1 of word k takes p_in byte j on the next edge.
  - More than one latch bit set: every selected word is written.
  - Writes while tip=1 are ignored.
- Start:
  - go=1 with tip=0 sets tip=1 on the next edge.
  - The same edge loads mosi with the bit at i=0 and clears rx_cnt and tx_cnt (tx_cnt=1 after the preload).
  - go while tip=1 is ignored; a write and go in the same cycle perform the write and do not start.
- rx edge (rx_negedge ? cpol_1 : cpol_0) with tip=1 and rx_cnt<L:
  - buffer[bit(rx_cnt)] <= miso.
  - rx_cnt increments.
- tx edge (tx_negedge ? cpol_1 : cpol_0) with tip=1 and tx_cnt<L:
  - Acts only if rx_cnt, counting a sample taken in the same cycle, is at least tx_cnt.
  - Action: mosi <= buffer[bit(tx_cnt)]; tx_cnt increments.
  - This makes the preloaded first bit valid for the first rx sample in all modes.
  - Once tx_cnt=L, mosi holds its value.
  - When rx and tx edges coincide: rx writes first; tx reads the pre-edge buffer value, which is an untouched bit.
- last = tip & (rx_cnt == L-1). Combinational from registers.
- End of transfer:
  - On the edge where rx_cnt reaches L: tip<=0 and done<=1 for exactly one cycle.
  - Latency: done is high in the cycle following the final rx pulse.
  - go held high re-arms the block from the cycle after tip falls.
- Received bits overwrite transmitted bits in place; bits at indices ≥ L are never modified.
- Edge pulses while tip=0 have no effect.
- cpol_0 and cpol_1 are never simultaneous; behaviour if both are asserted together is undefined.

Test Plan:
- Reset: drive wb_rst=1 for one edge -> mosi, tip, last, done all 0 and p_out=0 on the next cycle.
- Mode 1 short transfer, LSB first:
  - Stimulus: latch=1, byte_sel=4'b0011, p_in=32'h0000aa55; then len=4, lsb=1, tx_negedge=1, rx_negedge=0, go=1; miso bits 1,0,1,1.
  - Required: mosi bits 1,0,1,0; p_out[3:0]=4'b1101; p_out[15:4]=12'haa5; exactly 4 rx samples; last high only before the 4th; one done pulse.
- Full-length loopback:
  - Stimulus: words = 128'hdeadbeef_01234567_89abcdef_cafef00d; len=0; lsb=0; mosi looped to miso; all four rx/tx_negedge combinations.
  - Required: p_out unchanged after 128 rx samples; the first mosi bit is 1 (bit 127).
- Write/go during transfer:
  - Stimulus: latch=4'b0100, p_in=32'hffffffff and go=1 while tip=1.
  - Required: word 2 unchanged; no restart; done pulses once.
- Reset mid-transfer:
  - Stimulus: assert wb_rst after 10 rx samples of a len=64 transfer.
  - Required: tip=0, p_out=0, no done pulse; the following go runs a clean 64-bit transfer.
- Partial byte write:
  - Stimulus: from reset, latch=4'b1000, byte_sel=4'b1010, p_in=32'h11223344.
  - Required: p_out[127:96]=32'h11003300; all other bits 0.
